// File: rtl/tinyalu_pkg.sv
// Shared opcode encodings and FSM state type for the parametrised tiny ALU.
package tinyalu_pkg;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;

  typedef enum logic {
    ST_IDLE,
    ST_MUL
  } state_t;

  // True for every opcode whose result is pushed in the accepting cycle.
  function automatic logic op_is_single(input logic [2:0] op);
    return (op != OP_NOP) && (op != OP_MUL);
  endfunction

endpackage

// File: rtl/tinyalu_res_fifo.sv
// Generic synchronous FIFO holding ALU result entries; pointers wrap on DEPTH (power of 2).
module tinyalu_res_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_en;
  logic             pop_en;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_en = push & ~full;
  assign pop_en  = pop & ~empty;
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_en, pop_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/tinyalu_param.sv
// Parametrised tiny ALU: valid/ready operand port, multi-cycle multiply, result FIFO with
// illegal-opcode error flag and a legacy one-cycle done pulse per result.
module tinyalu_param
  import tinyalu_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int MUL_LAT    = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   A,
  input  logic [DATA_W-1:0]   B,
  input  logic [2:0]          op,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*DATA_W-1:0] result,
  output logic                err,
  output logic                done,
  output logic                busy
);

  localparam int RES_W = 2 * DATA_W;
  localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam int FC_W  = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic             err;
    logic [RES_W-1:0] result;
  } res_entry_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic             accept;
  logic             push;
  res_entry_t       alu_entry;
  res_entry_t       mul_entry;
  res_entry_t       fifo_din;
  res_entry_t       head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [FC_W-1:0]  unused_fifo_count;

  // Handshakes are strict valid/ready: a transfer happens on a rising clk edge where both
  // valid and ready are high. in_ready never looks at out_ready, and is low during reset.
  assign in_ready  = rst_n & (state == ST_IDLE) & ~fifo_full;
  assign accept    = in_valid & in_ready;
  assign busy      = (state == ST_MUL);
  assign out_valid = ~fifo_empty;
  assign result    = head.result;
  assign err       = head.err;

  always_comb begin
    alu_entry = '0;
    case (op)
      OP_ADD:          alu_entry.result = RES_W'(A) + RES_W'(B);
      OP_AND:          alu_entry.result = RES_W'(A & B);
      OP_XOR:          alu_entry.result = RES_W'(A ^ B);
      OP_NOP, OP_MUL:  alu_entry.result = '0;
      default:         alu_entry.err    = 1'b1;
    endcase
  end

  assign mul_entry.err    = 1'b0;
  assign mul_entry.result = RES_W'(a_q) * RES_W'(b_q);

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    fifo_din  = alu_entry;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (op == OP_MUL)        state_nxt = ST_MUL;
          else if (op_is_single(op)) push    = 1'b1;
        end
      end
      ST_MUL: begin
        fifo_din = mul_entry;
        if (cnt == '0) begin
          push      = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= push;
      if (accept && (op == OP_MUL)) begin
        a_q <= A;
        b_q <= B;
        cnt <= CNT_W'(MUL_LAT - 1);
      end else if ((state == ST_MUL) && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  tinyalu_res_fifo #(
    .WIDTH (RES_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_res_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (fifo_din),
    .pop   (out_ready),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (unused_fifo_count)
  );

endmodule

// File: tb/tb_tinyalu_param.sv
// Directed bench for tinyalu_param (DATA_W=8, MUL_LAT=3, FIFO_DEPTH=4) with an
// in-order scoreboard on every result pop.
module tb_tinyalu_param;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [2:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        err;
  logic        done;
  logic        busy;

  int tests  = 0;
  int failed = 0;
  logic [16:0] exp_q[$];

  tinyalu_param #(
    .DATA_W     (8),
    .MUL_LAT    (3),
    .FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .err       (err),
    .done      (done),
    .busy      (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish, expected finish before 1ms");
    $fatal(1, "watchdog");
  end

  function automatic logic [16:0] model(input logic [2:0] o, input logic [7:0] a,
                                        input logic [7:0] b);
    case (o)
      3'b001:  return {1'b0, 16'(a) + 16'(b)};
      3'b010:  return {1'b0, 8'h00, a & b};
      3'b011:  return {1'b0, 8'h00, a ^ b};
      3'b100:  return {1'b0, 16'(a) * 16'(b)};
      default: return {1'b1, 16'h0000};
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: record accepts into the model, score pops, then settle past the edge.
  task automatic tick();
    if (in_valid && in_ready && (op != 3'b000))
      exp_q.push_back(model(op, A, B));
    if (out_valid && out_ready) begin
      check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("sb_data", {15'd0, err, result}, 32'(exp_q.pop_front()));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    in_valid = 1'b1;
    op = o;
    A  = a;
    B  = b;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int i = 0; i < 40 && (out_valid || busy); i++) tick();
    check("drain_queue", exp_q.size(), 32'd0);
    check("drain_out_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic got;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    op = 3'b000;
    A = 8'h00;
    B = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick();

    // add FF+01
    drive(3'b001, 8'hFF, 8'h01);
    check("add_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("add_out_valid", 32'(out_valid), 32'd1);
    check("add_result", 32'(result), 32'h0100);
    check("add_err", 32'(err), 32'd0);
    check("add_done", 32'(done), 32'd1);
    tick();
    check("add_done_pulse", 32'(done), 32'd0);
    check("add_popped", 32'(out_valid), 32'd0);

    // mul FF*FF
    drive(3'b100, 8'hFF, 8'hFF);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("mul_in_ready", 32'(in_ready), 32'd0);
      check("mul_busy", 32'(busy), 32'd1);
      check("mul_out_valid", 32'(out_valid), 32'd0);
      tick();
    end
    check("mul_result", 32'(result), 32'hFE01);
    check("mul_valid", 32'(out_valid), 32'd1);
    check("mul_done", 32'(done), 32'd1);
    check("mul_busy_off", 32'(busy), 32'd0);
    check("mul_in_ready_back", 32'(in_ready), 32'd1);
    tick();

    // fill the FIFO with out_ready low
    out_ready = 1'b0;
    drive(3'b010, 8'hF0, 8'h3C); check("fill0_ready", 32'(in_ready), 32'd1); tick();
    drive(3'b011, 8'hA5, 8'h5A); check("fill1_ready", 32'(in_ready), 32'd1); tick();
    drive(3'b001, 8'h80, 8'h80); check("fill2_ready", 32'(in_ready), 32'd1); tick();
    drive(3'b010, 8'hFF, 8'h0F); check("fill3_ready", 32'(in_ready), 32'd1); tick();
    drive(3'b001, 8'h01, 8'h02);
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_head", 32'(result), 32'h0030);
    tick();
    check("full_hold_ready", 32'(in_ready), 32'd0);
    check("full_hold_head", 32'(result), 32'h0030);
    out_ready = 1'b1;
    tick();
    check("pop_in_ready", 32'(in_ready), 32'd1);
    check("pop_head", 32'(result), 32'h00FF);
    tick();
    check("refill_head", 32'(result), 32'h0100);
    drain();

    // illegal opcode then no_op
    out_ready = 1'b0;
    drive(3'b111, 8'h12, 8'h34);
    tick();
    check("ill_valid", 32'(out_valid), 32'd1);
    check("ill_result", 32'(result), 32'h0000);
    check("ill_err", 32'(err), 32'd1);
    check("ill_done", 32'(done), 32'd1);
    drive(3'b000, 8'h55, 8'h66);
    tick();
    in_valid = 1'b0;
    check("nop_done", 32'(done), 32'd0);
    check("nop_err_held", 32'(err), 32'd1);
    tick();
    check("nop_no_entry_done", 32'(done), 32'd0);
    drain();

    // reset during a multiply with two entries queued
    out_ready = 1'b0;
    drive(3'b001, 8'h01, 8'h01); tick();
    drive(3'b011, 8'h0F, 8'hF0); tick();
    drive(3'b100, 8'h02, 8'h03);
    check("rm_mul_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check("rm_out_valid", 32'(out_valid), 32'd0);
    check("rm_busy", 32'(busy), 32'd0);
    check("rm_in_ready", 32'(in_ready), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("rm_no_result", 32'(out_valid), 32'd0);
    end

    // 20 random ops against the model, consumer mostly stalled so the FIFO fills
    for (int n = 0; n < 20; n++) begin
      drive(3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      got = 1'b0;
      for (int c = 0; c < 60 && !got; c++) begin
        out_ready = ($urandom_range(0, 3) == 0);
        got = in_ready;
        tick();
      end
      check("rand_accept", 32'(got), 32'd1);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
